// File: rtl/router_req_gen.sv
// Router request generator: issues NUM_REQ address-stepped requests, times each out and counts results.
// Latency statistics are compiled in only when ROUTER_REQ_LATENCY_EN is defined.
module router_req_gen #(
    parameter int NUM_REQ     = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int GAP_CYC     = 8
) (
    input  logic        user_clk,
    input  logic        reset_pb,
    input  logic        gen_start,
    input  logic        gen_abort,
    input  logic [9:0]  cfg_src_addr,
    input  logic [9:0]  cfg_dst_base,
    input  logic [9:0]  cfg_dst_step,
    input  logic        router_done,
    output logic        router_start_req,
    output logic [9:0]  router_dst_addr,
    output logic [9:0]  router_scr_addr,
    output logic        busy,
    output logic        run_done,
    output logic [15:0] ok_cnt,
    output logic [15:0] timeout_cnt,
    output logic [15:0] stray_cnt,
    output logic [15:0] last_latency,
    output logic [15:0] max_latency,
    output logic [2:0]  state_dbg
);

    // Handshake: router_start_req is a level held for every WAIT cycle with stable addresses;
    // the request completes in the first cycle router_done is sampled high while it is set.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYC);
    localparam logic [15:0] GAP_L     = 16'(GAP_CYC);
    localparam logic [16:0] NUM_L     = 17'(NUM_REQ);

    state_t      state;
    logic [9:0]  src_q;
    logic [9:0]  step_q;
    logic [9:0]  dst_acc;
    logic [15:0] idx;
    logic [15:0] wait_cnt;
    logic [15:0] gap_cnt;
    logic        more_req;

    assign more_req  = ({1'b0, idx} + 17'd1) < NUM_L;
    assign state_dbg = state;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef ROUTER_REQ_LATENCY_EN
    logic [15:0] last_lat_q;
    logic [15:0] max_lat_q;
    assign last_latency = last_lat_q;
    assign max_latency  = max_lat_q;
`else
    assign last_latency = 16'd0;
    assign max_latency  = 16'd0;
`endif

    always_ff @(posedge user_clk) begin
        if (reset_pb) begin
            state            <= S_IDLE;
            router_start_req <= 1'b0;
            router_dst_addr  <= 10'd0;
            router_scr_addr  <= 10'd0;
            busy             <= 1'b0;
            run_done         <= 1'b0;
            ok_cnt           <= 16'd0;
            timeout_cnt      <= 16'd0;
            stray_cnt        <= 16'd0;
            src_q            <= 10'd0;
            step_q           <= 10'd0;
            dst_acc          <= 10'd0;
            idx              <= 16'd0;
            wait_cnt         <= 16'd0;
            gap_cnt          <= 16'd0;
`ifdef ROUTER_REQ_LATENCY_EN
            last_lat_q       <= 16'd0;
            max_lat_q        <= 16'd0;
`endif
        end else begin
            // A done outside WAIT is only counted; the later IDLE clear wins on a start cycle.
            if (router_done && state != S_WAIT)
                stray_cnt <= sat_inc(stray_cnt);

            case (state)
                S_IDLE: begin
                    if (gen_start) begin
                        src_q       <= cfg_src_addr;
                        dst_acc     <= cfg_dst_base;
                        step_q      <= cfg_dst_step;
                        idx         <= 16'd0;
                        ok_cnt      <= 16'd0;
                        timeout_cnt <= 16'd0;
                        stray_cnt   <= 16'd0;
`ifdef ROUTER_REQ_LATENCY_EN
                        last_lat_q  <= 16'd0;
                        max_lat_q   <= 16'd0;
`endif
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    router_dst_addr  <= dst_acc;
                    router_scr_addr  <= src_q;
                    router_start_req <= 1'b1;
                    wait_cnt         <= 16'd1;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    if (router_done) begin
                        ok_cnt           <= sat_inc(ok_cnt);
`ifdef ROUTER_REQ_LATENCY_EN
                        last_lat_q       <= wait_cnt;
                        if (wait_cnt > max_lat_q)
                            max_lat_q    <= wait_cnt;
`endif
                        router_start_req <= 1'b0;
                        gap_cnt          <= 16'd1;
                        state            <= S_GAP;
                    end else if (wait_cnt >= TIMEOUT_L) begin
                        timeout_cnt      <= sat_inc(timeout_cnt);
                        router_start_req <= 1'b0;
                        gap_cnt          <= 16'd1;
                        state            <= S_GAP;
                    end else begin
                        wait_cnt         <= wait_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    // Abort is only looked at here, so an in-flight request always finishes.
                    if (gap_cnt >= GAP_L) begin
                        if (more_req && !gen_abort) begin
                            idx     <= idx + 16'd1;
                            dst_acc <= dst_acc + step_q;
                            state   <= S_ISSUE;
                        end else begin
                            run_done <= 1'b1;
                            state    <= S_FINISH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                S_FINISH: begin
                    run_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    router_start_req <= 1'b0;
                    run_done         <= 1'b0;
                    busy             <= 1'b0;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule
